alu_seq: RTL and testbench

//  Parametrised, clocked successor to the combinational datapath ALU. Accepts one operation
//  per valid/ready handshake and returns a registered result plus Z/N/C/O flags.
//  1-cycle ops finish in one cycle. MUL/DIV/MOD run iteratively, one bit per cycle.

---
 rtl/alu_seq_if.sv | 18 +
 rtl/alu_seq.sv | 150 +++++++++++++++
 tb/tb_alu_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation request/response handshake bundle for alu_seq.
interface alu_seq_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       opcode;
  logic             store;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             wr_en;
  modport master (output in_valid, opcode, store, a, b, out_ready,
                  input  in_ready, out_valid, result, flags, wr_en);
  modport slave  (input  in_valid, opcode, store, a, b, out_ready,
                  output in_ready, out_valid, result, flags, wr_en);
endinterface

// File: rtl/alu_seq.sv
// alu_seq: clocked ALU, one op per handshake, iterative MUL/DIV/MOD, {Z,N,C,O} flags.
// Define ALU_SEQ_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  localparam int M = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {M{1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {M{1'b0}}};
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam bit ITER_MUL = 1'b0;
`else
  localparam bit ITER_MUL = 1'b1;
`endif
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
  state_t             state_q;
  logic [WIDTH-1:0]   result_q, opd_q;
  logic [3:0]         flags_q;
  logic               out_valid_q, wr_en_q, mod_q;
  logic [SHW-1:0]     cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_n, mul_n, div_n;
  logic [WIDTH:0]     add_w, sub_w, inc_w, mul_s, div_sh;
  logic [WIDTH-1:0]   res_d, div_r, fin_r;
  logic [3:0]         flg_d, fin_f;
  logic               c_d, o_d, we_d, zn_d, big_sh, div_ge, mul_it, div_it;
  logic [SHW-1:0]     sh;
  logic [SHW:0]       rsh;
`ifdef ALU_SEQ_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod_w;
  assign prod_w = bus.a * bus.b;
`endif
  assign add_w  = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_w  = {1'b0, bus.a} - {1'b0, bus.b};
  assign inc_w  = {1'b0, bus.a} + (WIDTH+1)'(1);
  assign sh     = bus.b[SHW-1:0];
  assign rsh    = (SHW+1)'(WIDTH) - {1'b0, sh};
  assign big_sh = (bus.b >> SHW) != '0;
  assign mul_it = ITER_MUL && bus.opcode == 6'h11;
  assign div_it = (bus.opcode == 6'h12 || bus.opcode == 6'h13) && bus.b != '0;
  always_comb begin
    res_d = '0;
    c_d   = 1'b0;
    o_d   = 1'b0;
    we_d  = 1'b1;
    zn_d  = 1'b1;
    case (bus.opcode)
      6'h0A: begin {c_d, res_d} = add_w; o_d = bus.a[M] == bus.b[M] && add_w[M] != bus.a[M]; end
      6'h0B, 6'h18: begin
        {c_d, res_d} = sub_w;
        o_d  = bus.a[M] != bus.b[M] && sub_w[M] != bus.a[M];
        we_d = bus.opcode == 6'h0B;
      end
      6'h0C: res_d = big_sh ? '0 : bus.a >> bus.b;
      6'h0D: res_d = big_sh ? '0 : bus.a << bus.b;
      6'h0E: res_d = (bus.a >> sh) | (bus.a << rsh);
      6'h0F: res_d = (bus.a << sh) | (bus.a >> rsh);
      6'h10: begin res_d = bus.b; zn_d = 1'b0; end
`ifdef ALU_SEQ_FAST_MUL_EN
      6'h11: begin res_d = prod_w[WIDTH-1:0]; o_d = prod_w[2*WIDTH-1:WIDTH] != '0; end
`endif
      6'h12: begin res_d = ONES; o_d = 1'b1; end
      6'h13: begin res_d = bus.a; o_d = 1'b1; end
      6'h14, 6'h19: begin res_d = bus.a & bus.b; we_d = bus.opcode == 6'h14; end
      6'h15: res_d = bus.a | bus.b;
      6'h16: res_d = bus.a ^ bus.b;
      6'h17: res_d = ~bus.a;
      6'h1A: begin {c_d, res_d} = inc_w; o_d = bus.a == SMAX; end
      6'h1B: begin res_d = bus.a - 1'b1; c_d = bus.a == '0; o_d = bus.a == SMIN; end
      default: begin we_d = 1'b0; zn_d = 1'b0; end
    endcase
    flg_d = zn_d ? {res_d == '0, res_d[M], c_d, o_d} : 4'b0;
  end
  // shift-add: acc = {partial high, remaining multiplier bits}
  assign mul_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & opd_q};
  assign mul_n  = {mul_s, acc_q[WIDTH-1:1]};
  // restoring division: acc = {remainder, dividend shifting into quotient}
  assign div_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge = div_sh >= {1'b0, opd_q};
  assign div_r  = div_ge ? WIDTH'(div_sh - {1'b0, opd_q}) : div_sh[WIDTH-1:0];
  assign div_n  = {div_r, acc_q[WIDTH-2:0], div_ge};
  assign acc_n  = state_q == S_MUL ? mul_n : div_n;
  assign fin_r  = state_q == S_DIV && mod_q ? acc_n[2*WIDTH-1:WIDTH] : acc_n[WIDTH-1:0];
  assign fin_f  = {fin_r == '0, fin_r[M], 1'b0, state_q == S_MUL && acc_n[2*WIDTH-1:WIDTH] != '0};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      mod_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      opd_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.in_valid) begin
          cnt_q <= '0;
          mod_q <= bus.opcode[0];
          if (bus.store) begin
            result_q    <= bus.a;
            wr_en_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (mul_it) begin
            acc_q   <= {{WIDTH{1'b0}}, bus.b};
            opd_q   <= bus.a;
            state_q <= S_MUL;
          end else if (div_it) begin
            acc_q   <= {{WIDTH{1'b0}}, bus.a};
            opd_q   <= bus.b;
            state_q <= S_DIV;
          end else begin
            result_q    <= res_d;
            flags_q     <= flg_d;
            wr_en_q     <= we_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_MUL, S_DIV: begin
          acc_q <= acc_n;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result_q    <= fin_r;
            flags_q     <= fin_f;
            wr_en_q     <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state_q == S_IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;
  assign bus.wr_en     = wr_en_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with hand-computed results and flags.
module tb_alu_seq;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 17;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;
  alu_seq_if #(.WIDTH(16)) bus ();
  alu_seq #(.WIDTH(16), .SHW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic pop();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask
  task automatic run(input string tag, input logic st, input logic [5:0] op,
                     input logic [15:0] a, input logic [15:0] b, input logic [15:0] er,
                     input logic [3:0] ef, input logic ew, input int el);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.store    = st;
    bus.opcode   = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.store    = 1'b0;
    bus.opcode   = 6'h0A;
    bus.a        = ~a;
    bus.b        = ~b;
    lat = 1;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(el));
    check({tag, ".res"}, 32'(bus.result), 32'(er));
    check({tag, ".flg"}, 32'(bus.flags), 32'(ef));
    check({tag, ".we"}, 32'(bus.wr_en), 32'(ew));
    pop();
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.store     = 1'b0;
    bus.opcode    = 6'h00;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.out_valid), 32'h0);
    check("rst.res", 32'(bus.result), 32'h0);
    check("rst.flg", 32'(bus.flags), 32'h0);
    check("rst.we", 32'(bus.wr_en), 32'h0);
    check("rst.rdy", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    //       tag       st    op     a         b         result    ZNCO     we    lat
    run("add_ovf",   1'b0, 6'h0A, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, 1'b1, 1);
    run("add_cy",    1'b0, 6'h0A, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, 1'b1, 1);
    run("mul",       1'b0, 6'h11, 16'h0100, 16'h0100, 16'h0000, 4'b1001, 1'b1, MUL_LAT);
    run("mul_ff",    1'b0, 6'h11, 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0001, 1'b1, MUL_LAT);
    run("mul_sm",    1'b0, 6'h11, 16'h0007, 16'h0009, 16'h003F, 4'b0000, 1'b1, MUL_LAT);
    run("div",       1'b0, 6'h12, 16'h0064, 16'h0007, 16'h000E, 4'b0000, 1'b1, 17);
    run("mod",       1'b0, 6'h13, 16'h0064, 16'h0007, 16'h0002, 4'b0000, 1'b1, 17);
    run("div_big",   1'b0, 6'h12, 16'hFFFF, 16'h0003, 16'h5555, 4'b0000, 1'b1, 17);
    run("div0",      1'b0, 6'h12, 16'h1234, 16'h0000, 16'hFFFF, 4'b0101, 1'b1, 1);
    run("mod0",      1'b0, 6'h13, 16'h1234, 16'h0000, 16'h1234, 4'b0001, 1'b1, 1);
    run("rsl",       1'b0, 6'h0F, 16'h8001, 16'h0011, 16'h0003, 4'b0000, 1'b1, 1);
    run("rsr0",      1'b0, 6'h0E, 16'h0001, 16'h0010, 16'h0001, 4'b0000, 1'b1, 1);
    run("rsr",       1'b0, 6'h0E, 16'h0001, 16'h0004, 16'h1000, 4'b0000, 1'b1, 1);
    run("lsr",       1'b0, 6'h0C, 16'h8000, 16'h000F, 16'h0001, 4'b0000, 1'b1, 1);
    run("lsl_big",   1'b0, 6'h0D, 16'hFFFF, 16'h0010, 16'h0000, 4'b1000, 1'b1, 1);
    run("store",     1'b1, 6'h0A, 16'hABCD, 16'h0001, 16'hABCD, 4'b1000, 1'b1, 1);
    run("cmp",       1'b0, 6'h18, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110, 1'b0, 1);
    run("sub",       1'b0, 6'h0B, 16'h0005, 16'h0003, 16'h0002, 4'b0000, 1'b1, 1);
    run("sub_ovf",   1'b0, 6'h0B, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, 1'b1, 1);
    run("mov",       1'b0, 6'h10, 16'h1111, 16'h8000, 16'h8000, 4'b0000, 1'b1, 1);
    run("inc_ovf",   1'b0, 6'h1A, 16'h7FFF, 16'h0000, 16'h8000, 4'b0101, 1'b1, 1);
    run("inc_cy",    1'b0, 6'h1A, 16'hFFFF, 16'h0000, 16'h0000, 4'b1010, 1'b1, 1);
    run("dec_ovf",   1'b0, 6'h1B, 16'h8000, 16'h0000, 16'h7FFF, 4'b0001, 1'b1, 1);
    run("dec_bw",    1'b0, 6'h1B, 16'h0000, 16'h0000, 16'hFFFF, 4'b0110, 1'b1, 1);
    run("not",       1'b0, 6'h17, 16'h00FF, 16'h0000, 16'hFF00, 4'b0100, 1'b1, 1);
    run("xor",       1'b0, 6'h16, 16'hF0F0, 16'hFFFF, 16'h0F0F, 4'b0000, 1'b1, 1);
    run("or",        1'b0, 6'h15, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000, 1'b1, 1);
    run("and",       1'b0, 6'h14, 16'h0FF0, 16'h00FF, 16'h00F0, 4'b0000, 1'b1, 1);
    run("tst",       1'b0, 6'h19, 16'h00F0, 16'h0F00, 16'h0000, 4'b1000, 1'b0, 1);
    run("unk",       1'b0, 6'h3F, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b0, 1);
    // completed result held while the consumer stalls; a second request is refused
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 6'h0A;
    bus.a        = 16'h0001;
    bus.b        = 16'h0002;
    @(posedge clk);
    #1;
    bus.opcode = 6'h0B;
    bus.a      = 16'h0009;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("hold.res", 32'(bus.result), 32'h0003);
      check("hold.flg", 32'(bus.flags), 32'h0);
      check("hold.vld", 32'(bus.out_valid), 32'h1);
      check("hold.rdy", 32'(bus.in_ready), 32'h0);
    end
    bus.in_valid = 1'b0;
    pop();
    check("hold.idle", 32'(bus.in_ready), 32'h1);
    check("hold.drop", 32'(bus.out_valid), 32'h0);
    // reset in the middle of a division discards it
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = 6'h12;
    bus.a        = 16'h0064;
    bus.b        = 16'h0007;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst.vld", 32'(bus.out_valid), 32'h0);
    check("mrst.res", 32'(bus.result), 32'h0);
    check("mrst.rdy", 32'(bus.in_ready), 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check("mrst.quiet", 32'(bus.out_valid), 32'h0);
    run("post_rst",  1'b0, 6'h13, 16'h0011, 16'h0005, 16'h0002, 4'b0000, 1'b1, 17);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
